ft245_link: RTL

- Cycle-accurate FT245 USB FIFO link engine that sits between the FT245 pins and the waveform/PHA memory controller.
- Receive side: reads host command bytes when RXF is low and presents each one as a single-cycle CMD/CMD_VLD pulse to the controller's command decoder.
- Transmit side: streams 16-bit SRAM words to the host as low byte then high byte, honouring TXE flow control and requesting address increments from the memory controller.

---
 rtl/ft245_link.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ft245_link.sv
// FT245 USB FIFO link engine: host command bytes are read on the RX side;
// 16-bit SRAM words are streamed out low byte first on the TX side.
module ft245_link #(
    parameter int RD_LOW_CYC  = 5,
    parameter int RD_GAP_CYC  = 2,
    parameter int WR_HIGH_CYC = 4,
    parameter int WR_LOW_CYC  = 6,
    parameter int LEN_W       = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    inout  wire  [7:0]       USBX,
    input  logic             RXF,
    input  logic             TXE,
    output logic             RD,
    output logic             WR,
    output logic [7:0]       CMD,
    output logic             CMD_VLD,
    input  logic             TX_START,
    input  logic [LEN_W-1:0] TX_LEN,
    input  logic [15:0]      RAM_DATA,
    output logic             ADR_INC,
    output logic             TX_BUSY,
    output logic             TX_DONE
);

    localparam int MAX_RD  = (RD_LOW_CYC > RD_GAP_CYC) ? RD_LOW_CYC : RD_GAP_CYC;
    localparam int MAX_WR  = (WR_HIGH_CYC > WR_LOW_CYC) ? WR_HIGH_CYC : WR_LOW_CYC;
    localparam int MAX_CYC = (MAX_RD > MAX_WR) ? MAX_RD : MAX_WR;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [3:0] {
        IDLE, RD_LOW, RD_GAP, TX_WAIT, TX_LO_HI, TX_LO_LO, TX_HI_HI, TX_HI_LO, TX_NEXT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [7:0]       hi_q, hi_d;
    logic [7:0]       dout_q, dout_d;
    logic             oe_q, oe_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic [7:0]       cmd_q, cmd_d;
    logic             vld_q, vld_d;
    logic             inc_q, inc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] len_even;

    // Odd lengths drop their last byte.
    assign len_even = {TX_LEN[LEN_W-1:1], 1'b0};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        dout_d  = dout_q;
        oe_d    = oe_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cmd_d   = cmd_q;
        busy_d  = busy_q;
        vld_d   = 1'b0;
        inc_d   = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (TX_START && (len_even != '0)) begin
                    rem_d   = len_even;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = TX_WAIT;
                end else begin
                    if (TX_START) done_d = 1'b1;
                    if (!RXF) begin
                        rd_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = RD_LOW;
                    end
                end
            end
            RD_LOW: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(RD_LOW_CYC - 1)) begin
                    cmd_d   = USBX;
                    vld_d   = 1'b1;
                    rd_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = RD_GAP;
                end
            end
            RD_GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(RD_GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            // One settle cycle keeps the RAM_DATA sample two cycles clear of ADR_INC.
            TX_WAIT: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(1);
                end else if (!TXE) begin
                    hi_d    = RAM_DATA[15:8];
                    dout_d  = RAM_DATA[7:0];
                    oe_d    = 1'b1;
                    wr_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = TX_LO_HI;
                end
            end
            TX_LO_HI, TX_HI_HI: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WR_HIGH_CYC - 1)) begin
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = (state_q == TX_LO_HI) ? TX_LO_LO : TX_HI_LO;
                end
            end
            TX_LO_LO: begin
                if (cnt_q != CNT_W'(WR_LOW_CYC - 1)) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!TXE) begin
                    dout_d  = hi_q;
                    wr_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = TX_HI_HI;
                end
            end
            TX_HI_LO: begin
                if (cnt_q != CNT_W'(WR_LOW_CYC - 1)) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    inc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = TX_NEXT;
                end
            end
            TX_NEXT: begin
                rem_d = (rem_q >= LEN_W'(2)) ? rem_q - LEN_W'(2) : '0;
                cnt_d = '0;
                if (rem_q <= LEN_W'(2)) begin
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = TX_WAIT;
                end
            end
            default: begin
                oe_d    = 1'b0;
                rd_d    = 1'b1;
                wr_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            dout_q  <= '0;
            oe_q    <= 1'b0;
            rd_q    <= 1'b1;
            wr_q    <= 1'b0;
            cmd_q   <= '0;
            vld_q   <= 1'b0;
            inc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cmd_q   <= cmd_d;
            vld_q   <= vld_d;
            inc_q   <= inc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign USBX    = oe_q ? dout_q : 8'bz;
    assign RD      = rd_q;
    assign WR      = wr_q;
    assign CMD     = cmd_q;
    assign CMD_VLD = vld_q;
    assign ADR_INC = inc_q;
    assign TX_BUSY = busy_q;
    assign TX_DONE = done_q;

endmodule
